mult_share_ctrl: RTL and testbench

- Sequences the shared 8x8 shift-add multiplier and time-shares it between two requesters.
- Arbitrates round-robin and captures the winner's operands.
- Drives the multiplier's start/operand inputs and counts a fixed latency instead of trusting the multiplier's done output.
- Samples the product and returns it to the owning requester with a one-cycle valid pulse.
- Sits between client logic and the multiplier instance.

---
 rtl/mult_pkg.sv | 14 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mult_share_ctrl.sv | 115 +++++++++++
 tb/tb_mult_share_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the multiplier sharing controller
package mult_pkg;

   localparam int WIDTH_DEF       = 8;
   localparam int MUL_LATENCY_DEF = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, one-hot grant, no internal state
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   input  logic       en,
   output logic [1:0] gnt
);

   // A lone request always wins; on a tie the requester opposite rr_ptr wins.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - time-shares one shift-add multiplier between two requesters
module mult_share_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0,
   input  logic [WIDTH-1:0]   a0,
   input  logic [WIDTH-1:0]   b0,
   output logic               gnt0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   a1,
   input  logic [WIDTH-1:0]   b1,
   output logic               gnt1,
   output logic               rsp_valid0,
   output logic               rsp_valid1,
   output logic [2*WIDTH-1:0] rsp_product,
   output logic               busy,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_product
);

   // Product is sampled on the edge that closes the last counted RUN cycle.
   localparam logic [3:0] LAST_COUNT = 4'(MUL_LATENCY - 1);

   state_t           state;
   state_t           state_nxt;
   logic             rr_ptr;
   logic [3:0]       count;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             owner;
   logic [1:0]       gnt_vec;

   rr_arb2 u_arb (
      .req    ({req1, req0}),
      .rr_ptr (rr_ptr),
      .en     (state == ST_IDLE),
      .gnt    (gnt_vec)
   );

   assign gnt0  = gnt_vec[0];
   assign gnt1  = gnt_vec[1];
   assign mul_a = op_a;
   assign mul_b = op_b;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and decoded outputs; the multiplier is held cleared in IDLE and loaded in LOAD.
   always_comb begin
      state_nxt  = state;
      mul_start  = 1'b0;
      busy       = 1'b1;
      rsp_valid0 = 1'b0;
      rsp_valid1 = 1'b0;
      case (state)
         ST_IDLE: begin
            mul_start = 1'b1;
            busy      = 1'b0;
            if (|gnt_vec) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            mul_start = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (count == LAST_COUNT) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid0 = ~owner;
            rsp_valid1 = owner;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, owner tracking and round-robin pointer update on a grant edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         owner  <= 1'b0;
         rr_ptr <= 1'b0;
      end else if (state == ST_IDLE && (|gnt_vec)) begin
         op_a   <= gnt_vec[1] ? a1 : a0;
         op_b   <= gnt_vec[1] ? b1 : b0;
         owner  <= gnt_vec[1];
         rr_ptr <= gnt_vec[1];
      end
   end

   // Fixed-latency counter; the multiplier's own done signal is deliberately not used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 count <= '0;
      else if (state == ST_LOAD)  count <= '0;
      else if (state == ST_RUN)   count <= count + 4'd1;
   end

   // Result register, held until the next sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     rsp_product <= '0;
      else if (state == ST_RUN && count == LAST_COUNT) rsp_product <= mul_product;
   end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - directed self-checking bench for mult_share_ctrl
module tb_mult_share_ctrl;

   localparam int WIDTH       = 8;
   localparam int MUL_LATENCY = 9;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [7:0]  a0, b0, a1, b1;
   logic        gnt0, gnt1;
   logic        rsp_valid0, rsp_valid1;
   logic [15:0] rsp_product;
   logic        busy;
   logic        mul_start;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_product;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   mult_share_ctrl #(.WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0        (req0),
      .a0          (a0),
      .b0          (b0),
      .gnt0        (gnt0),
      .req1        (req1),
      .a1          (a1),
      .b1          (b1),
      .gnt1        (gnt1),
      .rsp_valid0  (rsp_valid0),
      .rsp_valid1  (rsp_valid1),
      .rsp_product (rsp_product),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Multiplier model: loads on mul_start, product only correct after MUL_LATENCY-1 low edges.
   logic [3:0] mcnt = 4'd0;
   logic [7:0] ma = 8'd0, mb = 8'd0;
   always @(posedge clk) begin
      if (mul_start) begin
         ma   <= mul_a;
         mb   <= mul_b;
         mcnt <= 4'd0;
      end else if (mcnt != 4'd15) begin
         mcnt <= mcnt + 4'd1;
      end
   end
   assign mul_product = (!mul_start && mcnt >= 4'(MUL_LATENCY - 1)) ?
                        ({8'd0, ma} * {8'd0, mb}) : ~({8'd0, ma} * {8'd0, mb});

   // Exclusivity of grants and responses, every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((gnt0 && gnt1) || (rsp_valid0 && rsp_valid1) ||
             ((gnt0 || gnt1) && (rsp_valid0 || rsp_valid1))) begin
            errors++;
            $display("FAIL exclusive: gnt=%b%b rsp_valid=%b%b at cycle %0d required no overlap",
                     gnt1, gnt0, rsp_valid1, rsp_valid0, cycle);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Issues one request from 'who', drops it after the grant cycle and waits for the response.
   task automatic issue(input bit who, input logic [7:0] a, input logic [7:0] b,
                        output bit gnt_now, output int lat, output logic [15:0] prod,
                        output int busy_cnt, output bit wrong);
      if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
      else     begin req0 = 1'b1; a0 = a; b0 = b; end
      #1;
      gnt_now  = who ? gnt1 : gnt0;
      lat      = -1;
      prod     = 16'hxxxx;
      busy_cnt = 0;
      wrong    = 1'b0;
      cyc();
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         #1;
         if (busy) busy_cnt++;
         if (who ? rsp_valid0 : rsp_valid1) wrong = 1'b1;
         if (who ? rsp_valid1 : rsp_valid0) begin
            lat  = i;
            prod = rsp_product;
            break;
         end
         cyc();
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (mul_start !== 1'b1) begin errors++; $display("FAIL reset_mul_start: got %b want 1", mul_start); end
      checks++;
      if (rsp_product !== 16'd0) begin errors++; $display("FAIL reset_product: got %0d want 0", rsp_product); end
      checks++;
      if ({rsp_valid1, rsp_valid0} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", {rsp_valid1, rsp_valid0}); end
      checks++;
      if ({mul_a, mul_b} !== 16'd0) begin errors++; $display("FAIL reset_operands: got %h want 0000", {mul_a, mul_b}); end
   endtask

   task automatic test_tie();
      int n;
      req0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
      req1 = 1'b1; a1 = 8'd7; b1 = 8'd9;
      #1;
      checks++;
      if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL tie_first_gnt: got %b want 10", {gnt1, gnt0}); end
      cyc();
      req1 = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rsp_valid1) begin n = i + 1; break; end
         cyc();
      end
      checks++;
      if (n != 11 || rsp_product !== 16'd63) begin
         errors++; $display("FAIL tie_first_rsp: lat %0d product %0d want lat 11 product 63", n, rsp_product);
      end
      cyc();
      #1;
      checks++;
      if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL tie_second_gnt: got %b want 01", {gnt1, gnt0}); end
      cyc();
      req0 = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rsp_valid0) begin n = i + 1; break; end
         cyc();
      end
      checks++;
      if (n != 11 || rsp_product !== 16'd15) begin
         errors++; $display("FAIL tie_second_rsp: lat %0d product %0d want lat 11 product 15", n, rsp_product);
      end
      cyc();
   endtask

   task automatic test_single();
      bit g, w; int lat, bc; logic [15:0] p;
      issue(1'b0, 8'd13, 8'd11, g, lat, p, bc, w);
      checks++;
      if (g !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", g); end
      checks++;
      if (lat != 11) begin errors++; $display("FAIL single_latency: got %0d want 11", lat); end
      checks++;
      if (p !== 16'd143) begin errors++; $display("FAIL single_product: got %0d want 143", p); end
      checks++;
      if (bc != 11) begin errors++; $display("FAIL single_busy: got %0d cycles want 11", bc); end
      checks++;
      if (w) begin errors++; $display("FAIL single_owner: got rsp_valid1 want rsp_valid0 only"); end
      cyc();
   endtask

   task automatic test_extremes();
      bit g, w; int lat, bc; logic [15:0] p;
      issue(1'b1, 8'd255, 8'd255, g, lat, p, bc, w);
      checks++;
      if (!g || lat != 11 || p !== 16'd65025 || w) begin
         errors++; $display("FAIL max_operands: gnt %b lat %0d product %0d want 1 11 65025", g, lat, p);
      end
      cyc();
      issue(1'b0, 8'd0, 8'd200, g, lat, p, bc, w);
      checks++;
      if (!g || lat != 11 || p !== 16'd0 || w) begin
         errors++; $display("FAIL zero_operand: gnt %b lat %0d product %0d want 1 11 0", g, lat, p);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      int pa[3] = '{2, 10, 100};
      int pb[3] = '{3, 20, 50};
      int ex[3] = '{6, 200, 5000};
      int gc[3];
      int k, r;
      k = 0; r = 0;
      req0 = 1'b1; a0 = 8'(pa[0]); b0 = 8'(pb[0]);
      for (int i = 0; i < 60 && r < 3; i++) begin
         #1;
         if (gnt0 && k < 3) begin gc[k] = cycle; k++; end
         if (rsp_valid0) begin
            checks++;
            if (rsp_product !== 16'(ex[r])) begin
               errors++; $display("FAIL b2b_product%0d: got %0d want %0d", r, rsp_product, ex[r]);
            end
            r++;
         end
         cyc();
         if (k < 3) begin a0 = 8'(pa[k]); b0 = 8'(pb[k]); end
         else req0 = 1'b0;
      end
      req0 = 1'b0;
      checks++;
      if (k != 3 || r != 3) begin errors++; $display("FAIL b2b_count: grants %0d responses %0d want 3 3", k, r); end
      else begin
         checks++;
         if (gc[1] - gc[0] != 12 || gc[2] - gc[1] != 12) begin
            errors++; $display("FAIL b2b_spacing: got %0d,%0d want 12,12", gc[1] - gc[0], gc[2] - gc[1]);
         end
      end
      cyc();
   endtask

   task automatic test_busy_ignore();
      int g1, v1, v0;
      logic [15:0] p;
      g1 = 0; v1 = 0; v0 = 0; p = 16'd0;
      req0 = 1'b1; a0 = 8'd6; b0 = 8'd7;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin errors++; $display("FAIL busy_setup_gnt: got %b want 1", gnt0); end
      for (int i = 1; i <= 20; i++) begin
         cyc();
         req0 = 1'b0;
         req1 = (i >= 4 && i <= 6);
         a1 = 8'd9; b1 = 8'd9;
         #1;
         if (gnt1) g1++;
         if (rsp_valid1) v1++;
         if (rsp_valid0) begin v0++; p = rsp_product; end
      end
      req1 = 1'b0;
      checks++;
      if (g1 != 0 || v1 != 0) begin errors++; $display("FAIL busy_ignored: gnt1 %0d rsp_valid1 %0d want 0 0", g1, v1); end
      checks++;
      if (v0 != 1 || p !== 16'd42) begin errors++; $display("FAIL busy_owner_rsp: count %0d product %0d want 1 42", v0, p); end
      cyc();
   endtask

   task automatic test_reset_mid();
      int v;
      bit g, w; int lat, bc; logic [15:0] p;
      v = 0;
      req0 = 1'b1; a0 = 8'd13; b0 = 8'd11;
      cyc();
      req0 = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || mul_start !== 1'b1) begin
         errors++; $display("FAIL midreset_state: busy %b mul_start %b want 0 1", busy, mul_start);
      end
      checks++;
      if (rsp_product !== 16'd0) begin errors++; $display("FAIL midreset_product: got %0d want 0", rsp_product); end
      cyc();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         #1;
         if (rsp_valid0 || rsp_valid1) v++;
         cyc();
      end
      checks++;
      if (v != 0) begin errors++; $display("FAIL midreset_no_rsp: got %0d pulses want 0", v); end
      issue(1'b0, 8'd13, 8'd11, g, lat, p, bc, w);
      checks++;
      if (!g || lat != 11 || p !== 16'd143) begin
         errors++; $display("FAIL midreset_reissue: gnt %b lat %0d product %0d want 1 11 143", g, lat, p);
      end
      cyc();
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
      cyc();
      cyc();
      test_reset();
      cyc();
      rst_n = 1'b1;
      test_tie();
      test_single();
      test_extremes();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
